fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_lookup.sv | 62 ++++++
 rtl/fwd_scoreboard.sv | 123 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
//
// stage_t is one in-flight pipeline entry. Its rd and data fields are sized
// to the largest register index and datapath width the scoreboard supports
// (FWD_RD_MAX / FWD_DATA_MAX). An instance stores its REG_W / DATA_W values
// zero-extended into these fields.
package fwd_pkg;

    localparam int FWD_ZERO_REG = 31;
    localparam int FWD_DATA_MAX = 64;
    localparam int FWD_RD_MAX   = 8;

    typedef struct packed {
        logic                    valid;
        logic [FWD_RD_MAX-1:0]   rd;
        logic                    is_load;
        logic                    ready;
        logic [FWD_DATA_MAX-1:0] data;
    } stage_t;

endpackage

// File: rtl/fwd_lookup.sv
// One forwarding lookup port: finds the youngest valid in-flight entry that
// writes the requested register and decides what value, if any, it forwards.
//
// Ports:
//   stages         in  DEPTH entries, index 0 youngest
//   ex_result      in  ALU result for the stage-0 entry this cycle
//   mem_data_valid in  load data for the stage-1 entry is present
//   mem_data       in  load data
//   addr           in  register index looked up
//   data           out forwarded value (0 when hit is low)
//   hit            out data is valid
//   dep            out matched entry exists but cannot forward yet
module fwd_lookup
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = FWD_ZERO_REG
) (
    input  stage_t [DEPTH-1:0] stages,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic               mem_data_valid,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic [REG_W-1:0]   addr,
    output logic [DATA_W-1:0]  data,
    output logic               hit,
    output logic               dep
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    logic found;

    // Scan youngest to oldest; the first match decides the outcome even when
    // it cannot forward, so an older value is never used in its place.
    always_comb begin
        data  = '0;
        hit   = 1'b0;
        dep   = 1'b0;
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && stages[k].valid && (addr != ZERO_IDX) &&
                (stages[k].rd == FWD_RD_MAX'(addr))) begin
                found = 1'b1;
                if (stages[k].ready) begin
                    hit  = 1'b1;
                    data = stages[k].data[DATA_W-1:0];
                end else if ((k == 0) && !stages[k].is_load) begin
                    hit  = 1'b1;
                    data = ex_result;
                end else if ((k == 1) && stages[k].is_load && mem_data_valid) begin
                    hit  = 1'b1;
                    data = mem_data;
                end else begin
                    dep = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks DEPTH in-flight register writers, captures
// ALU results and load data as they become available, and serves NREAD
// bypass lookups. stall flags any lookup that hits a producer whose value
// is not yet available; stall_cnt counts stall cycles, saturating.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   advance         pipeline moves one stage this cycle
//   flush           discard all in-flight entries (overrides advance)
//   ins_valid/ins_rd/ins_is_load  instruction entering stage 0 on advance
//   ex_result       ALU result of the stage-0 entry
//   mem_data_valid/mem_data       load data for the stage-1 entry
//   rd_addr         NREAD packed lookup indices
//   rd_data/rd_hit  NREAD forwarded values and their valid bits
//   stall           some lookup depends on an unready producer
//   stall_cnt       saturating stall-cycle count
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = FWD_ZERO_REG,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    advance,
    input  logic                    flush,
    input  logic                    ins_valid,
    input  logic [REG_W-1:0]        ins_rd,
    input  logic                    ins_is_load,
    input  logic [DATA_W-1:0]       ex_result,
    input  logic                    mem_data_valid,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic [NREAD*REG_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_hit,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    stage_t [DEPTH-1:0] stg;
    stage_t             s0_in;
    stage_t             s0_out;
    stage_t             s1_eff;
    logic               capture;
    logic [NREAD-1:0]   dep;

    // Load data is captured into stage 1 whether or not the pipe moves.
    assign capture = stg[1].valid && stg[1].is_load && !stg[1].ready && mem_data_valid;

    always_comb begin
        // Entry created by the instruction entering stage 0.
        s0_in         = '0;
        s0_in.valid   = ins_valid && (ins_rd != ZERO_IDX);
        s0_in.rd      = FWD_RD_MAX'(ins_rd);
        s0_in.is_load = ins_is_load;

        // Stage-0 entry as it leaves for stage 1: ALU ops pick up their result.
        s0_out = stg[0];
        if (stg[0].valid && !stg[0].is_load) begin
            s0_out.ready = 1'b1;
            s0_out.data  = FWD_DATA_MAX'(ex_result);
        end

        // Stage-1 entry including any load data arriving this cycle.
        s1_eff = stg[1];
        if (capture) begin
            s1_eff.ready = 1'b1;
            s1_eff.data  = FWD_DATA_MAX'(mem_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg       <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stg[k].valid <= 1'b0;
                end
            end else if (advance) begin
                // The oldest entry falls off the end.
                stg[0] <= s0_in;
                stg[1] <= s0_out;
                for (int k = 2; k < DEPTH; k++) begin
                    stg[k] <= (k == 2) ? s1_eff : stg[k-1];
                end
            end else if (capture) begin
                stg[1] <= s1_eff;
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_lookup
        fwd_lookup #(
            .DATA_W   (DATA_W),
            .REG_W    (REG_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_lookup (
            .stages         (stg),
            .ex_result      (ex_result),
            .mem_data_valid (mem_data_valid),
            .mem_data       (mem_data),
            .addr           (rd_addr[p*REG_W +: REG_W]),
            .data           (rd_data[p*DATA_W +: DATA_W]),
            .hit            (rd_hit[p]),
            .dep            (dep[p])
        );
    end

    assign stall = |dep;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard (CNT_W = 4 build so saturation is reachable).
module tb_fwd_scoreboard;

    localparam int DATA_W   = 64;
    localparam int REG_W    = 5;
    localparam int DEPTH    = 3;
    localparam int NREAD    = 2;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    advance;
    logic                    flush;
    logic                    ins_valid;
    logic [REG_W-1:0]        ins_rd;
    logic                    ins_is_load;
    logic [DATA_W-1:0]       ex_result;
    logic                    mem_data_valid;
    logic [DATA_W-1:0]       mem_data;
    logic [NREAD*REG_W-1:0]  rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_hit;
    logic                    stall;
    logic [CNT_W-1:0]        stall_cnt;

    fwd_scoreboard #(
        .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH),
        .NREAD(NREAD), .ZERO_REG(ZERO_REG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .ins_valid(ins_valid), .ins_rd(ins_rd), .ins_is_load(ins_is_load),
        .ex_result(ex_result), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the pipeline as a queue of instructions, youngest first.
    typedef struct {
        bit          v;
        int unsigned rd;
        bit          ld;
        bit          rdy;
        logic [63:0] d;
    } ent_t;

    ent_t        pipe[$];
    int unsigned m_cnt;
    bit          m_stall;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_lookup(input int unsigned a, output bit hit,
                                         output logic [63:0] d, output bit dep);
        hit = 0; d = '0; dep = 0;
        if (a == ZERO_REG) return;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe[i].v && pipe[i].rd == a) begin
                if (pipe[i].rdy) begin
                    hit = 1; d = pipe[i].d;
                end else if (i == 0 && !pipe[i].ld) begin
                    hit = 1; d = ex_result;
                end else if (i == 1 && pipe[i].ld && mem_data_valid) begin
                    hit = 1; d = mem_data;
                end else begin
                    dep = 1;
                end
                return;
            end
        end
    endfunction

    task automatic check_outputs();
        bit          h;
        bit          dp;
        logic [63:0] d;
        m_stall = 0;
        for (int p = 0; p < NREAD; p++) begin
            model_lookup(int'(rd_addr[p*REG_W +: REG_W]), h, d, dp);
            chk($sformatf("rd_hit[%0d]", p), 64'(rd_hit[p]), 64'(h));
            chk($sformatf("rd_data[%0d]", p), rd_data[p*DATA_W +: DATA_W], d);
            if (dp) m_stall = 1;
        end
        chk("stall", 64'(stall), 64'(m_stall));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        ent_t e;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i].v = 0;
            m_cnt = 0;
            return;
        end
        if (m_stall && m_cnt != CNT_MAX) m_cnt++;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i].v = 0;
            return;
        end
        if (pipe[1].v && pipe[1].ld && !pipe[1].rdy && mem_data_valid) begin
            pipe[1].rdy = 1;
            pipe[1].d   = mem_data;
        end
        if (advance) begin
            if (pipe[0].v && !pipe[0].ld) begin
                pipe[0].rdy = 1;
                pipe[0].d   = ex_result;
            end
            e.v   = ins_valid && (int'(ins_rd) != ZERO_REG);
            e.rd  = int'(ins_rd);
            e.ld  = ins_is_load;
            e.rdy = 0;
            e.d   = '0;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endtask

    task automatic eval();
        @(negedge clk);
        check_outputs();
        model_edge();
    endtask

    task automatic adv_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        eval();
        adv_clk();
    endtask

    task automatic drive(input bit adv, input bit fl, input bit iv, input int ird,
                         input bit ild, input logic [63:0] ex, input bit mv,
                         input logic [63:0] md, input int a0, input int a1);
        advance        = adv;
        flush          = fl;
        ins_valid      = iv;
        ins_rd         = REG_W'(ird);
        ins_is_load    = ild;
        ex_result      = ex;
        mem_data_valid = mv;
        mem_data       = md;
        rd_addr        = {REG_W'(a1), REG_W'(a0)};
    endtask

    initial begin
        ent_t z;
        z.v = 0; z.rd = 0; z.ld = 0; z.rdy = 0; z.d = '0;
        for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
        m_cnt   = 0;
        m_stall = 0;

        // Reset: first edge brings the DUT out of X, then check reset outputs.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        @(posedge clk); #1;
        model_edge();
        tick();
        reset = 1'b0;

        // ALU write of rd=3 forwarded from stage 0, then from stage 1.
        drive(1, 0, 1, 3, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h55, 0, 64'h0, 3, 0);
        eval();
        chk("alu_s0_hit", 64'(rd_hit[0]), 64'd1);
        chk("alu_s0_data", rd_data[DATA_W-1:0], 64'h55);
        adv_clk();
        drive(1, 0, 0, 0, 0, 64'h55, 0, 64'h0, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h99, 0, 64'h0, 3, 0);
        eval();
        chk("alu_s1_hit", 64'(rd_hit[0]), 64'd1);
        chk("alu_s1_data", rd_data[DATA_W-1:0], 64'h55);
        adv_clk();

        // Load rd=4 waits for memory, then forwards mem_data same cycle.
        drive(1, 0, 1, 4, 1, 64'h0, 0, 64'h0, 3, 0);
        tick();
        drive(1, 0, 0, 0, 0, 64'h0, 0, 64'h0, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 4, 0);
        eval();
        chk("load_wait_stall", 64'(stall), 64'd1);
        chk("load_wait_hit", 64'(rd_hit[0]), 64'd0);
        adv_clk();
        drive(0, 0, 0, 0, 0, 64'h0, 1, 64'hAA, 4, 0);
        eval();
        chk("load_arr_hit", 64'(rd_hit[0]), 64'd1);
        chk("load_arr_data", rd_data[DATA_W-1:0], 64'hAA);
        chk("load_arr_stall", 64'(stall), 64'd0);
        adv_clk();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 4, 0);
        tick();

        // Two writers of rd=7: the younger one (stage 1) wins on both ports.
        drive(1, 0, 1, 7, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(1, 0, 1, 7, 0, 64'h1, 0, 64'h0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 64'h2, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 7, 7);
        eval();
        chk("young_p0", rd_data[DATA_W-1:0], 64'h2);
        chk("young_p1", rd_data[2*DATA_W-1:DATA_W], 64'h2);
        adv_clk();

        // Zero register never forwards; flush beats advance with a pending load.
        drive(1, 0, 1, 31, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h77, 0, 64'h0, 31, 31);
        eval();
        chk("zero_reg_hit", 64'(rd_hit), 64'd0);
        adv_clk();
        drive(1, 0, 1, 9, 1, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 9, 0);
        tick();
        drive(1, 1, 1, 9, 1, 64'h0, 0, 64'h0, 9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 9, 9);
        eval();
        chk("flush_hit", 64'(rd_hit), 64'd0);
        chk("flush_stall", 64'(stall), 64'd0);
        adv_clk();

        // Hold a stall for 2^CNT_W+3 cycles: counter sticks at all-ones.
        drive(1, 0, 1, 10, 1, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 10, 0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
        eval();
        chk("cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
        adv_clk();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 10, 0);
        eval();
        chk("cnt_reset", 64'(stall_cnt), 64'd0);
        adv_clk();

        // Oldest entry retires on advance.
        drive(1, 0, 1, 12, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 64'h12, 0, 64'h0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 12, 0);
        eval();
        chk("oldest_hit", 64'(rd_hit[0]), 64'd1);
        chk("oldest_data", rd_data[DATA_W-1:0], 64'h12);
        adv_clk();
        drive(1, 0, 0, 0, 0, 64'h0, 0, 64'h0, 12, 0);
        tick();
        drive(0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 12, 0);
        eval();
        chk("retired_hit", 64'(rd_hit[0]), 64'd0);
        adv_clk();

        // Randomized traffic over a small register set to force collisions.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1,
                  {$urandom, $urandom},
                  $urandom_range(0, 9) < 4,
                  {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
